// File: rtl/reset_seq_pkg.sv
// Shared definitions for the PLL reset sequencer: state encoding and default parameters.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        RUN       = 2'd2
    } seq_state_e;

    localparam int DEF_LOCK_STABLE_CYCLES = 1024;
    localparam int DEF_CNT_W              = 16;
    localparam int DEF_LOSS_CNT_W         = 8;
    localparam int DEF_TIMEOUT_CYCLES     = 1000000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, cleared by a synchronous reset.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Holds downstream logic in reset until PLL lock has been stable, re-arms on lock loss.
// Optional lock watchdog enabled by defining RESET_SEQ_WATCHDOG_EN.
//
//   state     | meaning
//   ----------+-------------------------------------------------------
//   WAIT_LOCK | core held in reset, waiting for synchronized lock
//   STABLE    | lock seen, counting consecutive locked cycles
//   RUN       | core released; any lock drop returns to WAIT_LOCK
module pll_reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
    parameter int CNT_W              = DEF_CNT_W,
    parameter int LOSS_CNT_W         = DEF_LOSS_CNT_W,
    parameter int TIMEOUT_CYCLES     = DEF_TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pll_locked,
    output logic                  core_reset,
    output logic                  ready,
    output logic [LOSS_CNT_W-1:0] lock_loss_count,
    output logic                  lock_timeout
);

    localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);

    logic                  lock_s;
    seq_state_e            state_q, state_d;
    logic [CNT_W-1:0]      stab_cnt_q, stab_cnt_d;
    logic [LOSS_CNT_W-1:0] loss_cnt_q, loss_cnt_d;
    logic                  core_reset_q, core_reset_d;
    logic                  ready_q, ready_d;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .reset (reset),
        .d     (pll_locked),
        .q     (lock_s)
    );

    always_comb begin
        state_d    = state_q;
        stab_cnt_d = stab_cnt_q;
        loss_cnt_d = loss_cnt_q;
        case (state_q)
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d    = STABLE;
                    stab_cnt_d = CNT_W'(1);
                end else begin
                    stab_cnt_d = '0;
                end
            end
            STABLE: begin
                // a drop always wins, even on the cycle the count completes
                if (!lock_s) begin
                    state_d    = WAIT_LOCK;
                    stab_cnt_d = '0;
                end else if (stab_cnt_q == STAB_LAST) begin
                    state_d    = RUN;
                    stab_cnt_d = '0;
                end else begin
                    stab_cnt_d = stab_cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_d    = WAIT_LOCK;
                    stab_cnt_d = '0;
                    if (loss_cnt_q != '1) begin
                        loss_cnt_d = loss_cnt_q + LOSS_CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d    = WAIT_LOCK;
                stab_cnt_d = '0;
            end
        endcase
        core_reset_d = (state_d != RUN);
        ready_d      = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= WAIT_LOCK;
            stab_cnt_q   <= '0;
            loss_cnt_q   <= '0;
            core_reset_q <= 1'b1;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            stab_cnt_q   <= stab_cnt_d;
            loss_cnt_q   <= loss_cnt_d;
            core_reset_q <= core_reset_d;
            ready_q      <= ready_d;
        end
    end

    assign core_reset      = core_reset_q;
    assign ready           = ready_q;
    assign lock_loss_count = loss_cnt_q;

`ifdef RESET_SEQ_WATCHDOG_EN
    localparam int            WD_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            timeout_q, timeout_d;

    always_comb begin
        wd_cnt_d  = wd_cnt_q;
        timeout_d = timeout_q;
        if (state_q == RUN || state_d == RUN) begin
            wd_cnt_d = '0;
        end else if (wd_cnt_q != WD_MAX) begin
            wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
        if (wd_cnt_d == WD_MAX) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign lock_timeout = timeout_q;
`else
    assign lock_timeout = (TIMEOUT_CYCLES == 0) & 1'b0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer with a short stability interval.
module tb_pll_reset_sequencer;

    localparam int LSC     = 16;
    localparam int REL_LAT = LSC + 2;
    localparam int LOSS_W  = 8;
    localparam int TMO     = 100;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              pll_locked = 1'b1;
    logic              core_reset;
    logic              ready;
    logic [LOSS_W-1:0] lock_loss_count;
    logic              lock_timeout;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];

    pll_reset_sequencer #(
        .LOCK_STABLE_CYCLES (LSC),
        .CNT_W              (5),
        .LOSS_CNT_W         (LOSS_W),
        .TIMEOUT_CYCLES     (TMO)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .pll_locked      (pll_locked),
        .core_reset      (core_reset),
        .ready           (ready),
        .lock_loss_count (lock_loss_count),
        .lock_timeout    (lock_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Edges until core_reset reaches want; -1 if the bound expires.
    task automatic edges_until(input logic want, input int limit, output int n);
        int k;
        k = 0;
        n = -1;
        while (k < limit) begin
            tick();
            k++;
            if (core_reset === want) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int e;
        pll_locked = 1'b1;
        reset      = 1'b1;
        repeat (4) tick();
        exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
        checks++; e = exp_q.pop_front();
        if (core_reset !== e[0]) begin failures++; $display("FAIL reset_core_reset got=%b exp=%0d", core_reset, e); end
        checks++; e = exp_q.pop_front();
        if (ready !== e[0]) begin failures++; $display("FAIL reset_ready got=%b exp=%0d", ready, e); end
        checks++; e = exp_q.pop_front();
        if (int'(lock_loss_count) !== e) begin failures++; $display("FAIL reset_loss_count got=%0d exp=%0d", lock_loss_count, e); end
        checks++; e = exp_q.pop_front();
        if (lock_timeout !== e[0]) begin failures++; $display("FAIL reset_timeout got=%b exp=%0d", lock_timeout, e); end
    endtask

    task automatic test_power_up();
        int n, e;
        reset = 1'b0;
        exp_q.push_back(REL_LAT);
        edges_until(1'b0, 100, n);
        checks++; e = exp_q.pop_front();
        if (n !== e) begin failures++; $display("FAIL powerup_latency got=%0d exp=%0d", n, e); end
        exp_q.push_back(1);
        checks++; e = exp_q.pop_front();
        if (ready !== e[0]) begin failures++; $display("FAIL powerup_ready got=%b exp=%0d", ready, e); end
    endtask

    task automatic test_glitch_stable();
        int n, e;
        pll_locked = 1'b1;
        reset      = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        repeat (12) tick();   // stability count now 10
        pll_locked = 1'b0;
        repeat (3) begin
            tick();
            exp_q.push_back(1);
            checks++; e = exp_q.pop_front();
            if (core_reset !== e[0]) begin failures++; $display("FAIL glitch_hold got=%b exp=%0d", core_reset, e); end
        end
        pll_locked = 1'b1;
        exp_q.push_back(REL_LAT);
        edges_until(1'b0, 100, n);
        checks++; e = exp_q.pop_front();
        if (n !== e) begin failures++; $display("FAIL glitch_latency got=%0d exp=%0d", n, e); end
    endtask

    task automatic test_loss_run();
        int n, e;
        pll_locked = 1'b0;
        exp_q.push_back(3);
        edges_until(1'b1, 20, n);
        checks++; e = exp_q.pop_front();
        if (n !== e) begin failures++; $display("FAIL loss_latency got=%0d exp=%0d", n, e); end
        exp_q.push_back(1); exp_q.push_back(0);
        checks++; e = exp_q.pop_front();
        if (int'(lock_loss_count) !== e) begin failures++; $display("FAIL loss_count got=%0d exp=%0d", lock_loss_count, e); end
        checks++; e = exp_q.pop_front();
        if (ready !== e[0]) begin failures++; $display("FAIL loss_ready got=%b exp=%0d", ready, e); end
        pll_locked = 1'b1;
        exp_q.push_back(REL_LAT);
        edges_until(1'b0, 100, n);
        checks++; e = exp_q.pop_front();
        if (n !== e) begin failures++; $display("FAIL relock_latency got=%0d exp=%0d", n, e); end
    endtask

    task automatic test_simultaneous();
        int n, e;
        pll_locked = 1'b0;
        edges_until(1'b1, 20, n);
        pll_locked = 1'b1;
        repeat (15) tick();
        pll_locked = 1'b0;    // lock_s low exactly when the count would complete
        tick();
        pll_locked = 1'b1;
        exp_q.push_back(REL_LAT);
        edges_until(1'b0, 100, n);
        checks++; e = exp_q.pop_front();
        if (n !== e) begin failures++; $display("FAIL simult_latency got=%0d exp=%0d", n, e); end
        exp_q.push_back(2);
        checks++; e = exp_q.pop_front();
        if (int'(lock_loss_count) !== e) begin failures++; $display("FAIL simult_count got=%0d exp=%0d", lock_loss_count, e); end
    endtask

    task automatic test_saturation();
        int n, e, model;
        pll_locked = 1'b1;
        reset      = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        edges_until(1'b0, 100, n);
        model = 0;
        for (int i = 0; i < 300; i++) begin
            pll_locked = 1'b0;
            edges_until(1'b1, 20, n);
            pll_locked = 1'b1;
            if (model < 255) model++;
            exp_q.push_back(REL_LAT);
            exp_q.push_back(model);
            edges_until(1'b0, 100, n);
            checks++; e = exp_q.pop_front();
            if (n !== e) begin failures++; $display("FAIL sat_relock i=%0d got=%0d exp=%0d", i, n, e); end
            checks++; e = exp_q.pop_front();
            if (int'(lock_loss_count) !== e) begin failures++; $display("FAIL sat_count i=%0d got=%0d exp=%0d", i, lock_loss_count, e); end
        end
    endtask

    task automatic test_reset_mid_run();
        int n, e;
        reset = 1'b1;
        tick();
        exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(0);
        checks++; e = exp_q.pop_front();
        if (core_reset !== e[0]) begin failures++; $display("FAIL rstrun_core_reset got=%b exp=%0d", core_reset, e); end
        checks++; e = exp_q.pop_front();
        if (ready !== e[0]) begin failures++; $display("FAIL rstrun_ready got=%b exp=%0d", ready, e); end
        checks++; e = exp_q.pop_front();
        if (int'(lock_loss_count) !== e) begin failures++; $display("FAIL rstrun_count got=%0d exp=%0d", lock_loss_count, e); end
        reset = 1'b0;
        exp_q.push_back(REL_LAT);
        edges_until(1'b0, 100, n);
        checks++; e = exp_q.pop_front();
        if (n !== e) begin failures++; $display("FAIL rstrun_latency got=%0d exp=%0d", n, e); end
    endtask

    task automatic test_reset_mid_stable();
        int n, e;
        pll_locked = 1'b0;
        edges_until(1'b1, 20, n);
        pll_locked = 1'b1;
        repeat (10) tick();   // stability count now 8
        exp_q.push_back(1);
        checks++; e = exp_q.pop_front();
        if (int'(lock_loss_count) !== e) begin failures++; $display("FAIL rststab_precount got=%0d exp=%0d", lock_loss_count, e); end
        reset = 1'b1;
        tick();
        exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(0);
        checks++; e = exp_q.pop_front();
        if (core_reset !== e[0]) begin failures++; $display("FAIL rststab_core_reset got=%b exp=%0d", core_reset, e); end
        checks++; e = exp_q.pop_front();
        if (ready !== e[0]) begin failures++; $display("FAIL rststab_ready got=%b exp=%0d", ready, e); end
        checks++; e = exp_q.pop_front();
        if (int'(lock_loss_count) !== e) begin failures++; $display("FAIL rststab_count got=%0d exp=%0d", lock_loss_count, e); end
        reset = 1'b0;
        exp_q.push_back(REL_LAT);
        edges_until(1'b0, 100, n);
        checks++; e = exp_q.pop_front();
        if (n !== e) begin failures++; $display("FAIL rststab_latency got=%0d exp=%0d", n, e); end
    endtask

    task automatic test_watchdog();
        int n, e;
        pll_locked = 1'b0;
        reset      = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
`ifdef RESET_SEQ_WATCHDOG_EN
        n = -1;
        for (int k = 1; k <= 200; k++) begin
            tick();
            if (lock_timeout === 1'b1) begin
                n = k;
                break;
            end
        end
        exp_q.push_back(TMO);
        checks++; e = exp_q.pop_front();
        if (n !== e) begin failures++; $display("FAIL wd_trip_cycle got=%0d exp=%0d", n, e); end
        pll_locked = 1'b1;
        exp_q.push_back(REL_LAT);
        edges_until(1'b0, 100, n);
        checks++; e = exp_q.pop_front();
        if (n !== e) begin failures++; $display("FAIL wd_release got=%0d exp=%0d", n, e); end
        repeat (20) tick();
        exp_q.push_back(1);
        checks++; e = exp_q.pop_front();
        if (lock_timeout !== e[0]) begin failures++; $display("FAIL wd_sticky got=%b exp=%0d", lock_timeout, e); end
`else
        n = 0;
        repeat (150) begin
            tick();
            if (lock_timeout !== 1'b0) n++;
        end
        exp_q.push_back(0);
        checks++; e = exp_q.pop_front();
        if (n !== e) begin failures++; $display("FAIL nowd_timeout_cycles got=%0d exp=%0d", n, e); end
        pll_locked = 1'b1;
        exp_q.push_back(REL_LAT);
        edges_until(1'b0, 100, n);
        checks++; e = exp_q.pop_front();
        if (n !== e) begin failures++; $display("FAIL nowd_release got=%0d exp=%0d", n, e); end
        exp_q.push_back(0);
        checks++; e = exp_q.pop_front();
        if (lock_timeout !== e[0]) begin failures++; $display("FAIL nowd_timeout got=%b exp=%0d", lock_timeout, e); end
`endif
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_glitch_stable();
        test_loss_run();
        test_simultaneous();
        test_saturation();
        test_reset_mid_run();
        test_reset_mid_stable();
        test_watchdog();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
